mul_booth_arbiter: RTL

- Shares one iterative radix-4 Booth multiplier core between NUM_REQ requesters using round-robin arbitration.
- Per transaction it captures the granted requester's operands, loads the core by pulsing the core's synchronous load/reset, waits for the core's done flag (with a watchdog), then returns the result tagged with the requester index over a valid/ready response channel.
- Sits between the integer ALU issue logic and the mul core; one operation is in flight at a time.

---
 rtl/mul_booth_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mul_booth_arbiter.sv
// -----------------------------------------------------------------------------
// mul_booth_arbiter
//
// Shares a single iterative radix-4 Booth multiplier core between NUM_REQ
// requesters. Requests are granted round-robin, one operation in flight at a
// time. For each transaction the granted operands are snapshotted, the core
// is loaded by pulsing its active-low load/reset for one cycle, and the
// controller then waits (with a watchdog) for the core's done flag. The
// result is returned on a valid/ready channel tagged with the requester id.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_req_valid/o_req_ready  per-requester handshake (ready is one-hot or 0)
//   i_req_a/i_req_b          packed signed operands, DATA_WIDTH per requester
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_id/res/cry/err     response payload (err = watchdog expired)
//   o_mul_rst_n              core load/reset, active-low
//   o_mul_a/o_mul_b          core operands (snapshotted)
//   i_mul_end/res/cry        core done flag, product and carry
//   o_busy                   controller is not idle
// -----------------------------------------------------------------------------
module mul_booth_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = DATA_WIDTH / 2 + 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_b,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    o_rsp_id,
  output logic [2*DATA_WIDTH-1:0]       o_rsp_res,
  output logic                          o_rsp_cry,
  output logic                          o_rsp_err,
  output logic                          o_mul_rst_n,
  output logic [DATA_WIDTH-1:0]         o_mul_a,
  output logic [DATA_WIDTH-1:0]         o_mul_b,
  input  logic                          i_mul_end,
  input  logic [2*DATA_WIDTH-1:0]       i_mul_res,
  input  logic                          i_mul_cry,
  output logic                          o_busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic [ID_W-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [ID_W-1:0]         r_id;
  logic                    r_rsp_valid;
  logic [2*DATA_WIDTH-1:0] r_rsp_res;
  logic                    r_rsp_cry;
  logic                    r_rsp_err;
  logic [CNT_W-1:0]        r_wait_cnt;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   w_req_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_req_b [NUM_REQ];
  logic [NUM_REQ-1:0]      w_mask;
  logic [NUM_REQ-1:0]      w_high;
  logic [ID_W-1:0]         w_grant_idx;
  logic                    w_any_valid;
  logic                    w_idle;
  logic                    w_handshake;
  logic [ID_W-1:0]         w_ptr_next;
  logic [DATA_WIDTH-1:0]   w_sel_a;
  logic [DATA_WIDTH-1:0]   w_sel_b;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_timeout;

  assign w_idle      = (r_state == S_IDLE);
  assign w_any_valid = |i_req_valid;

  // Unpack the per-requester operand slices, and build the round-robin mask
  // that keeps only requesters at or above the pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_a[gi] = i_req_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_req_b[gi] = i_req_b[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_mask[gi]  = (ID_W'(gi) >= r_ptr);
    end
  endgenerate

  // Round-robin grant: lowest valid index at/above the pointer; if none,
  // wrap around and take the lowest valid index overall. Loops run from the
  // top down so the lowest matching index is the last assignment.
  always_comb begin
    w_high      = i_req_valid & w_mask;
    w_grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_grant_idx = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_high[i]) begin
        w_grant_idx = ID_W'(i);
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a = w_req_a[i];
        w_sel_b = w_req_b[i];
      end
    end
  end

  // Ready is offered only while idle and out of reset, and only to the grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign o_req_ready[gi] = i_rst_n & w_idle & w_any_valid &
                               (w_grant_idx == ID_W'(gi));
    end
  endgenerate

  assign w_handshake = |(i_req_valid & o_req_ready);
  assign w_ptr_next  = (w_grant_idx == ID_W'(NUM_REQ - 1)) ?
                       '0 : (w_grant_idx + ID_W'(1));

  // Watchdog: w_cnt_next is the 1-based number of the current WAIT cycle.
  assign w_cnt_next = r_wait_cnt + CNT_W'(1);
  assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_cry   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_grant_idx;
            r_ptr   <= w_ptr_next;
            r_state <= S_LOAD;
          end
        end

        // Core samples the operands at the end of this cycle.
        S_LOAD: begin
          r_wait_cnt <= '0;
          r_state    <= S_SETTLE;
        end

        // The core's done flag is still the previous operation's value here.
        S_SETTLE: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_wait_cnt <= w_cnt_next;
          if (i_mul_end) begin
            r_rsp_res   <= i_mul_res;
            r_rsp_cry   <= i_mul_cry;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_res   <= '0;
            r_rsp_cry   <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The core is held in reset together with the controller.
  assign o_mul_rst_n = i_rst_n & (r_state != S_LOAD);
  assign o_mul_a     = r_a;
  assign o_mul_b     = r_b;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_id;
  assign o_rsp_res   = r_rsp_res;
  assign o_rsp_cry   = r_rsp_cry;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule
